tx_zc_re_map: RTL and testbench
===============================

// Module: tx_zc_re_map
// PURPOSE
//  Downstream consumer of the ZC generator output stream (C12S9 complex samples with valid).
//  Buffers one complete ZC sequence, then maps it onto the FFT subcarrier grid.
//  Mapping: start bin k0, comb spacing 1/2/4; all other bins are zero-filled.
//  Streams NFFT bins in natural order to the IFFT stage over a valid/ready handshake.
// PARAMETERS
//  DATA_WIDTH     12  bits per I and per Q component
//  NFFT_LOG2      12  log2 of FFT size (NFFT = 4096 bins per symbol)
//  BUF_ADDR_W     12  ZC buffer address width (depth 2^BUF_ADDR_W = 4096 samples)
// PORTS
//  sys_clk        in   1            single clock; all logic on rising edge
//  rst            in   1            synchronous, active-high reset
//  k0             in   NFFT_LOG2    first occupied bin; latched on accepted start
//  comb           in   2            bin spacing: 0->1, 1->2, 2->4, 3->reserved (treated as 4)
//  zc_len         in   12           ZC samples to collect; latched on accepted start
//  conj           in   1            conjugate output; used only with TX_ZC_RE_MAP_CONJ_EN
//  start          in   1            1-cycle pulse; accepted only in IDLE
//  zc_in_valid    in   1            ZC sample strobe (no backpressure toward ZC generator)
//  zc_in_data     in   2*DATA_WIDTH {I[23:12],Q[11:0]} C12S9
//  out_valid      out  1            output bin valid
//  out_ready      in   1            IFFT accepts the bin when out_valid&&out_ready
//  out_data       out  2*DATA_WIDTH {I,Q}; bin value, zero on unoccupied bins
//  out_last       out  1            high with bin NFFT-1
//  busy           out  1            high in every state except IDLE
//  done           out  1            1-cycle pulse after out_last is accepted
//  err_drop       out  1            1-cycle pulse when a zc_in_valid sample is discarded
// BEHAVIOUR
//  Reset: all outputs 0; FSM to IDLE; write/read counters to 0. Buffer contents undefined.
//   Reset mid-operation aborts the symbol; no done pulse is issued.
//  FSM states:
//   IDLE->FILL on start.
//   FILL: write zc_in_data to buf[wr_cnt], wr_cnt++; FILL->EMIT when wr_cnt==zc_len.
//    zc_len==0 goes straight to EMIT.
//   EMIT: bin counter k runs 0..NFFT-1; advances only on accepted output; EMIT->DONE on accepted out_last.
//   DONE: done=1 for one cycle; DONE->IDLE.
//  Occupancy: d=(k-k0) mod NFFT. Bin k is occupied iff d%step==0 and d/step<zc_len.
//   The bin then carries buf[d/step]; otherwise it is 0.
//   step=1<<comb. Bins past NFFT-1 wrap to bin 0 (modulo NFFT).
//   If step*zc_len>NFFT, samples beyond the NFFT-th bin position are never emitted.
//  Buffer: 1-cycle read latency. Read addressing is prefetched into a 2-entry skid so that
//   out_valid can stay high every cycle while out_ready=1.
//   out_data/out_last stay stable while out_valid&&!out_ready.
//  Latency: first out_valid is asserted 2 cycles after the last FILL write (or after start if zc_len==0).
//  start while busy: ignored (no latch, no error).
//  zc_in_valid outside FILL: sample dropped, err_drop=1 that cycle.
//  Buffer overflow: zc_len>2^BUF_ADDR_W is clamped to 2^BUF_ADDR_W.
//  Throughput: 1 bin/cycle sustained in EMIT with out_ready=1. FILL accepts 1 sample/cycle.
// CONFIGURATION
//  TX_ZC_RE_MAP_CONJ_EN defined:
//   Output Q is negated when conj (latched at start) is 1.
//   Negation saturates: -(-2048) -> +2047. I is unchanged. Zero bins stay zero.
//   Adds no latency.
//  Undefined: conj is ignored; out_data is the buffered sample unmodified.
// TESTING
//  T1 zc_len=12, k0=0, comb=0, ramp samples 1..12:
//   bins 0..11 carry 1..12, bins 12..4095 are 0; out_last on bin 4095; done 1 cycle later.
//  T2 zc_len=139, k0=4000, comb=1:
//   bins 4000,4002,...,4094 carry samples 0..47; bin 0 carries sample 48 (wrap).
//   Samples 48..138 occupy bins 0,2,...,180; odd bins are 0.
//  T3 random out_ready (50% duty) during T2:
//   output sequence identical to T2; no bin lost or duplicated.
//   out_data held stable while stalled.
//  T4 start pulsed in FILL and EMIT, plus zc_in_valid pulsed in EMIT:
//   start ignored; err_drop pulses once per stray sample; output unchanged.
//  T5 rst asserted at bin 1000 of EMIT:
//   next cycle out_valid=0, busy=0, done=0. A following start with zc_len=30 completes normally.
//  T6 (CONJ_EN) conj=1, sample Q=-2048, I=5:
//   out_data I=5, Q=2047. With macro undefined: Q=-2048.

Source files
------------

// File: rtl/tx_zc_re_map.sv
// tx_zc_re_map
//   Collects one ZC sequence (C12S9 complex samples) into a local buffer, then
//   streams all NFFT bins of one symbol in natural order. Occupied bins start at
//   k0, are spaced 1/2/4 bins apart and wrap modulo NFFT. Every other bin is zero.
//
// Optional build macro: TX_ZC_RE_MAP_CONJ_EN
//   When defined, Q is negated (with saturation) for symbols started with conj=1.
//   When undefined, conj is ignored.
//
// Ports
//   sys_clk, rst        single clock, synchronous active-high reset
//   k0, comb, zc_len    symbol setup, latched on an accepted start
//   conj                conjugate request, latched on an accepted start
//   start               1-cycle start pulse, only honoured in IDLE
//   zc_in_valid/data    ZC sample stream, no backpressure
//   out_valid/ready     bin handshake toward the IFFT
//   out_data, out_last  bin value {I,Q}; out_last marks bin NFFT-1
//   busy, done          busy outside IDLE; done pulses after the last bin
//   err_drop            pulses in the cycle a ZC sample is discarded
//
// state  | meaning
// -------+------------------------------------------------------------
// S_IDLE | waiting for start
// S_FILL | writing ZC samples into the buffer until zc_len are stored
// S_EMIT | streaming bins 0..NFFT-1
// S_DONE | one-cycle done pulse, then back to IDLE
module tx_zc_re_map #(
  parameter int DATA_WIDTH = 12,
  parameter int NFFT_LOG2  = 12,
  parameter int BUF_ADDR_W = 12
) (
  input  logic                    sys_clk,
  input  logic                    rst,
  input  logic [NFFT_LOG2-1:0]    k0,
  input  logic [1:0]              comb,
  input  logic [11:0]             zc_len,
  input  logic                    conj,
  input  logic                    start,
  input  logic                    zc_in_valid,
  input  logic [2*DATA_WIDTH-1:0] zc_in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [2*DATA_WIDTH-1:0] out_data,
  output logic                    out_last,
  output logic                    busy,
  output logic                    done,
  output logic                    err_drop
);

  localparam int DW        = 2 * DATA_WIDTH;
  localparam int BUF_DEPTH = 1 << BUF_ADDR_W;
  localparam int CNT_W     = BUF_ADDR_W + 1;
  localparam logic [NFFT_LOG2-1:0] K_LAST = '1;

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_EMIT, S_DONE} state_t;
  state_t state, state_nxt;

  logic [NFFT_LOG2-1:0]  k0_q;
  logic [1:0]            comb_q;
  logic [CNT_W-1:0]      len_q;
  logic [CNT_W-1:0]      len_clamp;
  logic [CNT_W-1:0]      wr_cnt;
  logic [NFFT_LOG2-1:0]  rd_k;
  logic                  rd_done;

  logic                  start_acc;
  logic                  wr_en;
  logic                  iss;
  logic                  acc;

  logic [NFFT_LOG2-1:0]  d;
  logic [NFFT_LOG2-1:0]  idx;
  logic [NFFT_LOG2-1:0]  step_mask;
  logic                  rd_occ;
  logic                  rd_last;
  logic [BUF_ADDR_W-1:0] rd_addr;

  logic [DW-1:0]         zc_buf [BUF_DEPTH];
  logic [DW-1:0]         buf_q;

  // Output stage: q is the buffer read register, s is the skid entry that
  // catches q when a new read lands while the consumer is stalled.
  logic                  q_v, q_occ, q_last;
  logic                  s_v, s_last;
  logic [DW-1:0]         s_data;
  logic [DW-1:0]         q_data;
  logic [DW-1:0]         sel;

  assign len_clamp = (32'(zc_len) > BUF_DEPTH) ? CNT_W'(BUF_DEPTH) : CNT_W'(zc_len);

  // FSM
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    start_acc = 1'b0;
    wr_en     = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          start_acc = 1'b1;
          state_nxt = S_FILL;
        end
      end
      S_FILL: begin
        if (wr_cnt == len_q) begin
          state_nxt = S_EMIT;
        end else begin
          wr_en = zc_in_valid;
        end
      end
      S_EMIT: begin
        if (acc && out_last) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  assign busy     = (state != S_IDLE);
  assign done     = (state == S_DONE);
  assign err_drop = zc_in_valid && !wr_en && !rst;

  // Setup latch and counters
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      k0_q    <= '0;
      comb_q  <= '0;
      len_q   <= '0;
      wr_cnt  <= '0;
      rd_k    <= '0;
      rd_done <= 1'b0;
    end else begin
      if (start_acc) begin
        k0_q    <= k0;
        comb_q  <= (comb == 2'd3) ? 2'd2 : comb;
        len_q   <= len_clamp;
        wr_cnt  <= '0;
        rd_k    <= '0;
        rd_done <= 1'b0;
      end
      if (wr_en) begin
        wr_cnt <= wr_cnt + CNT_W'(1);
      end
      if (iss) begin
        rd_k <= rd_k + NFFT_LOG2'(1);
        if (rd_k == K_LAST) begin
          rd_done <= 1'b1;
        end
      end
    end
  end

  // Bin-to-sample lookup for the bin being read
  always_comb begin
    step_mask = '0;
    case (comb_q)
      2'd1:    step_mask = NFFT_LOG2'(1);
      2'd2:    step_mask = NFFT_LOG2'(3);
      default: step_mask = '0;
    endcase
  end

  assign d       = rd_k - k0_q;
  assign idx     = d >> comb_q;
  assign rd_occ  = ((d & step_mask) == '0) && (32'(idx) < 32'(len_q));
  assign rd_addr = BUF_ADDR_W'(idx);
  assign rd_last = (rd_k == K_LAST);

  // A read may only be issued while the skid is empty, so q always has
  // somewhere to go if the consumer stalls in the same cycle.
  assign iss = (state == S_EMIT) && !rd_done && !s_v;

  // Sample buffer (contents are not reset)
  always_ff @(posedge sys_clk) begin
    if (wr_en) begin
      zc_buf[wr_cnt[BUF_ADDR_W-1:0]] <= zc_in_data;
    end
    if (iss) begin
      buf_q <= zc_buf[rd_addr];
    end
  end

  assign q_data = (q_v && q_occ) ? buf_q : '0;
  assign sel    = s_v ? s_data : q_data;

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      q_v    <= 1'b0;
      q_occ  <= 1'b0;
      q_last <= 1'b0;
      s_v    <= 1'b0;
      s_last <= 1'b0;
      s_data <= '0;
    end else if (iss) begin
      q_v    <= 1'b1;
      q_occ  <= rd_occ;
      q_last <= rd_last;
      if (q_v && !out_ready) begin
        s_v    <= 1'b1;
        s_data <= q_data;
        s_last <= q_last;
      end
    end else if (s_v) begin
      if (out_ready) begin
        s_v <= 1'b0;
      end
    end else if (q_v && out_ready) begin
      q_v <= 1'b0;
    end
  end

  assign out_valid = q_v || s_v;
  assign out_last  = s_v ? s_last : (q_v && q_last);
  assign acc       = out_valid && out_ready;

`ifdef TX_ZC_RE_MAP_CONJ_EN
  logic                  conj_q;
  logic [DATA_WIDTH-1:0] q_part;
  logic [DATA_WIDTH-1:0] q_neg;

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      conj_q <= 1'b0;
    end else if (start_acc) begin
      conj_q <= conj;
    end
  end

  // The most negative code has no positive counterpart; pin it to full scale.
  assign q_part   = sel[DATA_WIDTH-1:0];
  assign q_neg    = (q_part == {1'b1, {(DATA_WIDTH-1){1'b0}}}) ?
                    {1'b0, {(DATA_WIDTH-1){1'b1}}} : -q_part;
  assign out_data = conj_q ? {sel[DW-1:DATA_WIDTH], q_neg} : sel;
`else
  logic unused_conj;
  assign unused_conj = conj;
  assign out_data    = sel;
`endif

endmodule

// File: tb/tb_tx_zc_re_map.sv
module tb_tx_zc_re_map;

  localparam int NFFT = 4096;

  logic        sys_clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] k0 = '0;
  logic [1:0]  comb = '0;
  logic [11:0] zc_len = '0;
  logic        conj = 1'b0;
  logic        start = 1'b0;
  logic        zc_in_valid = 1'b0;
  logic [23:0] zc_in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [23:0] out_data;
  logic        out_last;
  logic        busy;
  logic        done;
  logic        err_drop;

  int checks = 0;
  int failures = 0;

  logic [23:0] samp [NFFT];
  logic [23:0] expv [NFFT];
  logic [23:0] got [$];
  int          last_pos;

  typedef struct {
    int          k0;
    int          comb;
    int          len;
    bit          conj;
    bit          rmode;
    int          pat;
    int          probe;
    logic [23:0] probe_exp;
    int          nz_exp;
  } vec_t;

  vec_t vecs [8];

`ifdef TX_ZC_RE_MAP_CONJ_EN
  localparam logic [23:0] T6_EXP = 24'h0057FF;
`else
  localparam logic [23:0] T6_EXP = 24'h005800;
`endif

  always #5 sys_clk = ~sys_clk;

  tx_zc_re_map dut (
    .sys_clk     (sys_clk),
    .rst         (rst),
    .k0          (k0),
    .comb        (comb),
    .zc_len      (zc_len),
    .conj        (conj),
    .start       (start),
    .zc_in_valid (zc_in_valid),
    .zc_in_data  (zc_in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_last    (out_last),
    .busy        (busy),
    .done        (done),
    .err_drop    (err_drop)
  );

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, req, req);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  // Conjugate of one sample: negate the signed Q component, clip at +2047.
  function automatic logic [23:0] conj_model(input logic [23:0] s);
    int q;
    int nq;
    logic [11:0] qb;
    q  = int'($signed(s[11:0]));
    nq = -q;
    if (nq > 2047) nq = 2047;
    qb = 12'(nq);
    return {s[23:12], qb};
  endfunction

  // Scatter sample i to bin (k0 + i*step) mod NFFT while i*step is inside one symbol.
  task automatic build_model(input int k0v, input int combv, input int lenv, input bit conjv);
    int  step;
    bit  use_conj;
    step = 1 << ((combv == 3) ? 2 : combv);
`ifdef TX_ZC_RE_MAP_CONJ_EN
    use_conj = conjv;
`else
    use_conj = 1'b0;
`endif
    for (int k = 0; k < NFFT; k++) expv[k] = '0;
    for (int i = 0; i < lenv; i++) begin
      int pos;
      pos = i * step;
      if (pos < NFFT) expv[(k0v + pos) % NFFT] = use_conj ? conj_model(samp[i]) : samp[i];
    end
  endtask

  task automatic run_symbol(input int k0v, input int combv, input int lenv, input bit conjv,
                            input bit rmode, input int abort_at, input bit disturb);
    logic        v1, v2, rdy, acc_now, lsave, prev_st, prev_l, timeout;
    logic [23:0] dsave, prev_d;
    int          drops, stall_err, mism, first_bad;

    build_model(k0v, combv, lenv, conjv);
    got.delete();
    last_pos  = -1;
    drops     = 0;
    stall_err = 0;

    k0 = 12'(k0v); comb = 2'(combv); zc_len = 12'(lenv); conj = conjv;
    start = 1'b1;
    tick();
    start = 1'b0;

    for (int i = 0; i < lenv; i++) begin
      zc_in_valid = 1'b1;
      zc_in_data  = samp[i];
      if (disturb && i == 2) begin
        start = 1'b1; k0 = 12'd9; zc_len = 12'd3; comb = 2'd0;
      end
      #1;
      if (err_drop) drops++;
      tick();
      start = 1'b0;
    end
    zc_in_valid = 1'b0;
    out_ready   = 1'b0;

    tick(); v1 = out_valid;
    tick(); v2 = out_valid;
    check("first_valid_latency", {v1, v2}, 2'b01);

    prev_st = 1'b0; prev_d = '0; prev_l = 1'b0; timeout = 1'b1;
    for (int cyc = 0; cyc < 20000; cyc++) begin
      if (abort_at > 0 && got.size() == abort_at) begin
        rst = 1'b1; out_ready = 1'b0;
        tick();
        rst = 1'b0;
        check("abort_outputs", {out_valid, busy, done}, 3'b000);
        v1 = 1'b0;
        for (int j = 0; j < 4; j++) begin
          tick();
          v1 = v1 | done | busy | out_valid;
        end
        check("abort_stays_idle", v1, 0);
        return;
      end
      if (prev_st && (!out_valid || out_data != prev_d || out_last != prev_l)) stall_err++;
      rdy = rmode ? 1'($urandom_range(0, 1)) : 1'b1;
      out_ready = rdy;
      if (disturb && cyc == 10) start = 1'b1;
      if (disturb && (cyc == 20 || cyc == 30 || cyc == 31)) zc_in_valid = 1'b1;
      #1;
      if (err_drop) drops++;
      acc_now = out_valid && rdy;
      dsave   = out_data;
      lsave   = out_last;
      prev_st = out_valid && !rdy;
      prev_d  = out_data;
      prev_l  = out_last;
      tick();
      start = 1'b0;
      zc_in_valid = 1'b0;
      if (acc_now) begin
        got.push_back(dsave);
        if (lsave) begin
          last_pos = got.size() - 1;
          timeout  = 1'b0;
          break;
        end
      end
    end
    check("emit_reached_last", timeout, 0);
    check("done_pulse", {done, busy}, 2'b11);
    out_ready = 1'b0;
    tick();
    check("done_clear", {done, busy}, 2'b00);

    check("bin_count", got.size(), NFFT);
    check("last_position", last_pos, NFFT - 1);
    mism = 0;
    first_bad = -1;
    for (int k = 0; k < got.size() && k < NFFT; k++) begin
      if (got[k] !== expv[k]) begin
        if (first_bad < 0) first_bad = k;
        mism++;
      end
    end
    if (first_bad >= 0)
      $display("first differing bin %0d: got %06h model %06h", first_bad, got[first_bad], expv[first_bad]);
    check("bin_data_vs_model", mism, 0);
    check("err_drop_count", drops, disturb ? 3 : 0);
    if (rmode) check("stall_hold", stall_err, 0);
  endtask

  initial begin
    vecs[0] = '{0,    0, 12,   1'b0, 1'b0, 0, 11,   24'd12,  12};
    vecs[1] = '{4000, 1, 139,  1'b0, 1'b0, 0, 0,    24'd49,  139};
    vecs[2] = '{100,  2, 1200, 1'b0, 1'b0, 0, 140,  24'd11,  1024};
    vecs[3] = '{5,    3, 3,    1'b0, 1'b0, 0, 13,   24'd3,   3};
    vecs[4] = '{7,    0, 0,    1'b0, 1'b0, 0, 7,    24'd0,   0};
    vecs[5] = '{4095, 0, 4095, 1'b0, 1'b0, 0, 4094, 24'd0,   4095};
    vecs[6] = '{4000, 1, 139,  1'b0, 1'b1, 0, 180,  24'd139, 139};
    vecs[7] = '{0,    0, 1,    1'b1, 1'b0, 1, 0,    T6_EXP,  1};

    rst = 1'b1;
    repeat (3) tick();
    check("reset_outputs", {out_valid, busy, done, err_drop, out_last, out_data}, 0);
    rst = 1'b0;
    tick();
    check("idle_after_reset", {out_valid, busy, done, err_drop, out_last}, 0);

    for (int v = 0; v < 8; v++) begin
      int nz;
      logic [23:0] pv;
      for (int i = 0; i < NFFT; i++) samp[i] = 24'(i + 1);
      if (vecs[v].pat == 1) samp[0] = {12'd5, 12'h800};
      run_symbol(vecs[v].k0, vecs[v].comb, vecs[v].len, vecs[v].conj, vecs[v].rmode, 0, 1'b0);
      nz = 0;
      foreach (got[k]) if (got[k] != '0) nz++;
      pv = (vecs[v].probe < got.size()) ? got[vecs[v].probe] : 24'hBADBAD;
      check($sformatf("vec%0d_probe_bin%0d", v, vecs[v].probe), pv, vecs[v].probe_exp);
      check($sformatf("vec%0d_occupied", v), nz, vecs[v].nz_exp);
    end

    // stray start pulses and stray samples
    for (int i = 0; i < NFFT; i++) samp[i] = 24'(i + 1);
    run_symbol(20, 0, 50, 1'b0, 1'b0, 0, 1'b1);

    // reset at bin 1000, then a normal short symbol
    run_symbol(4000, 1, 139, 1'b0, 1'b0, 1000, 1'b0);
    run_symbol(0, 1, 30, 1'b0, 1'b0, 0, 1'b0);

    // randomized symbols against the model
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < NFFT; i++) samp[i] = 24'($urandom);
      run_symbol(int'($urandom_range(0, NFFT - 1)), int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 300)), 1'($urandom_range(0, 1)), (r == 0), 0, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
